vx_tcu_drl_excep_acc: RTL and testbench

Sequential exception tracker for the TCU dot-product (FEDP) datapath. It classifies every product lane of each issued K-step, folds the result into a sticky per-tile accumulator across a multi-step sequence (first…last), and emits the final IEEE special-value outcome once per tile. It sits beside the FEDP mantissa pipeline, and its `out_excep` overrides the numeric result at writeback. Unlike the single-step combinational checker, it is parametrised in lane count and pipeline depth, spans K-step sequences, and reports invalid-operation and sequencing errors.

---
 rtl/vx_tcu_drl_excep_acc_pkg.sv | 56 +++++
 rtl/vx_tcu_excep_lane.sv | 25 ++
 rtl/vx_tcu_drl_excep_acc.sv | 174 +++++++++++++++++
 tb/tb_vx_tcu_drl_excep_acc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_drl_excep_acc_pkg.sv
// Shared types for the TCU FEDP exception tracker: operand/result classes,
// format IDs, the per-tile accumulator and the per-beat reduced flags.
package vx_tcu_drl_excep_acc_pkg;

  localparam logic [2:0] TCU_FP32_ID = 3'd0;
  localparam logic [2:0] TCU_FP16_ID = 3'd1;
  localparam logic [2:0] TCU_BF16_ID = 3'd2;

  // Accumulator counter width; MAX_STEPS must fit in it.
  localparam int unsigned ACC_CNTW = 8;

  typedef struct packed {
    logic sign;
    logic nan;
    logic inf;
    logic zero;
  } fedp_class_t;

  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
  } fedp_excep_t;

  typedef struct packed {
    logic                nan;
    logic                pos;
    logic                neg;
    logic                nv;
    logic                err;
    logic [ACC_CNTW-1:0] cnt;
  } tcu_excep_acc_t;

  // One classified beat after lane reduction, plus the seed taken from c.
  typedef struct packed {
    logic first;
    logic last;
    logic seed_nan;
    logic seed_pos;
    logic seed_neg;
    logic any_nan;
    logic any_pos;
    logic any_neg;
    logic any_nv;
  } tcu_excep_beat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } tcu_excep_state_t;

  function automatic logic fmt_supported(input logic [2:0] fmt);
    return (fmt == TCU_FP32_ID) || (fmt == TCU_FP16_ID) || (fmt == TCU_BF16_ID);
  endfunction

endpackage

// File: rtl/vx_tcu_excep_lane.sv
// Combinational classifier for one product lane a*b.
// Ports: a, b operand classes; en effective lane mask;
//        nan_c/inf_c product is NaN/Inf, sign_c product sign, nv_c inf*zero.
module vx_tcu_excep_lane
  import vx_tcu_drl_excep_acc_pkg::*;
(
  input  fedp_class_t a,
  input  fedp_class_t b,
  input  logic        en,
  output logic        nan_c,
  output logic        inf_c,
  output logic        sign_c,
  output logic        nv_c
);

  logic inf_z;

  // inf * 0 is the only invalid product; it yields NaN, never Inf.
  assign inf_z  = (a.inf & b.zero) | (a.zero & b.inf);
  assign nan_c  = (a.nan | b.nan | inf_z) & en;
  assign inf_c  = (a.inf | b.inf) & ~inf_z & en;
  assign sign_c = a.sign ^ b.sign;
  assign nv_c   = inf_z & en;

endmodule

// File: rtl/vx_tcu_drl_excep_acc.sv
// Sequential exception tracker for the FEDP datapath. Classifies each
// K-step beat, folds it into a sticky per-tile accumulator and emits the
// IEEE special-value outcome once per tile on the last beat.
// Ports: clk/reset_n; in_* step beat (valid/ready, first/last, fmt, mask,
//        lane classes a/b, accumulator class c); out_* tile result
//        (valid/ready, excep, nv, seq_err, steps).
module vx_tcu_drl_excep_acc
  import vx_tcu_drl_excep_acc_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned PIPE_S1   = 1,
  parameter int unsigned MAX_STEPS = 16,
  localparam int unsigned TCK      = 2 * N,
  localparam int unsigned CNTW     = $clog2(MAX_STEPS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [2:0]              in_fmt,
  input  logic [TCK-1:0]          in_mask,
  input  fedp_class_t [TCK-1:0]   cls_a,
  input  fedp_class_t [TCK-1:0]   cls_b,
  input  fedp_class_t             cls_c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output fedp_excep_t             out_excep,
  output logic                    out_nv,
  output logic                    out_seq_err,
  output logic [CNTW-1:0]         out_steps
);

  // Whole pipeline stalls only while a result sits unaccepted.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- Lane classification ----------------
  logic           fmt_ok;
  logic [TCK-1:0] eff_mask;
  logic [TCK-1:0] l_nan;
  logic [TCK-1:0] l_inf;
  logic [TCK-1:0] l_sign;
  logic [TCK-1:0] l_nv;

  assign fmt_ok = fmt_supported(in_fmt);

  for (genvar i = 0; i < TCK; i++) begin : g_lane
    // TF32 packs one product per lane pair; odd lanes carry no data.
    assign eff_mask[i] = in_mask[i] & fmt_ok &
                         ((in_fmt != TCU_FP32_ID) | ((i % 2) == 0));

    vx_tcu_excep_lane u_lane (
      .a      (cls_a[i]),
      .b      (cls_b[i]),
      .en     (eff_mask[i]),
      .nan_c  (l_nan[i]),
      .inf_c  (l_inf[i]),
      .sign_c (l_sign[i]),
      .nv_c   (l_nv[i])
    );
  end

  // Reduce lanes to per-beat flags; an unsupported format poisons the beat.
  tcu_excep_beat_t beat_c;
  always_comb begin
    beat_c          = '0;
    beat_c.first    = in_first;
    beat_c.last     = in_last;
    beat_c.seed_nan = cls_c.nan;
    beat_c.seed_pos = cls_c.inf & ~cls_c.sign;
    beat_c.seed_neg = cls_c.inf & cls_c.sign;
    beat_c.any_nan  = (|l_nan) | ~fmt_ok;
    beat_c.any_pos  = |(l_inf & ~l_sign);
    beat_c.any_neg  = |(l_inf & l_sign);
    beat_c.any_nv   = (|l_nv) | ~fmt_ok;
  end

  logic unused_cls_c;
  assign unused_cls_c = cls_c.zero;

  // ---------------- Optional S1 register ----------------
  logic            s1_valid;
  tcu_excep_beat_t s1_beat;

  if (PIPE_S1 != 0) begin : g_s1_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_valid <= 1'b0;
        s1_beat  <= '0;
      end else if (adv) begin
        s1_valid <= in_valid;
        s1_beat  <= beat_c;
      end
    end
  end else begin : g_s1_bypass
    assign s1_valid = in_valid;
    assign s1_beat  = beat_c;
  end

  // ---------------- Accumulator (S2) ----------------
  tcu_excep_state_t state_q;
  tcu_excep_acc_t   acc_q;
  tcu_excep_acc_t   base_c;
  tcu_excep_acc_t   next_c;

  // Pick the base the beat folds into, then OR in the beat flags.
  always_comb begin
    base_c = acc_q;
    if (s1_beat.first) begin
      base_c     = '0;
      base_c.nan = s1_beat.seed_nan;
      base_c.pos = s1_beat.seed_pos;
      base_c.neg = s1_beat.seed_neg;
      // A new first while a tile is open abandons that tile.
      base_c.err = (state_q == ST_ACCUM);
    end else if (state_q == ST_IDLE) begin
      // Orphan beat: start clean, c is not sampled, flag the tile.
      base_c     = '0;
      base_c.err = 1'b1;
    end

    next_c     = base_c;
    next_c.nan = base_c.nan | s1_beat.any_nan;
    next_c.pos = base_c.pos | s1_beat.any_pos;
    next_c.neg = base_c.neg | s1_beat.any_neg;
    next_c.nv  = base_c.nv  | s1_beat.any_nv;
    next_c.cnt = (base_c.cnt >= ACC_CNTW'(MAX_STEPS)) ? ACC_CNTW'(MAX_STEPS)
                                                      : base_c.cnt + ACC_CNTW'(1);
  end

  // Final IEEE outcome: +inf and -inf together collapse to an invalid NaN.
  logic        clash_c;
  logic        res_nan_c;
  fedp_excep_t res_excep_c;

  assign clash_c            = next_c.pos & next_c.neg;
  assign res_nan_c          = next_c.nan | clash_c;
  assign res_excep_c.is_nan = res_nan_c;
  assign res_excep_c.is_inf = (next_c.pos | next_c.neg) & ~res_nan_c;
  assign res_excep_c.sign   = next_c.neg & ~next_c.pos;

  // Tile sequencing, accumulator update and registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_valid   <= 1'b0;
      out_excep   <= '0;
      out_nv      <= 1'b0;
      out_seq_err <= 1'b0;
      out_steps   <= '0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_beat.last) begin
          state_q     <= ST_IDLE;
          acc_q       <= '0;
          out_valid   <= 1'b1;
          out_excep   <= res_excep_c;
          out_nv      <= next_c.nv | clash_c;
          out_seq_err <= next_c.err;
          out_steps   <= CNTW'(next_c.cnt);
        end else begin
          state_q <= ST_ACCUM;
          acc_q   <= next_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_tcu_drl_excep_acc.sv
// Self-checking bench for vx_tcu_drl_excep_acc: a behavioural model pushes
// expected tile results on each accepted beat; a monitor pops and compares
// them as the DUT hands results over.
module tb_vx_tcu_drl_excep_acc;
  import vx_tcu_drl_excep_acc_pkg::*;

  localparam int unsigned N         = 2;
  localparam int unsigned TCK       = 2 * N;
  localparam int unsigned MAX_STEPS = 16;
  localparam int unsigned CNTW      = $clog2(MAX_STEPS + 1);

  typedef fedp_class_t [TCK-1:0] lanes_t;

  typedef struct packed {
    logic            sign;
    logic            is_nan;
    logic            is_inf;
    logic            nv;
    logic            err;
    logic [CNTW-1:0] steps;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic              in_last;
  logic [2:0]        in_fmt;
  logic [TCK-1:0]    in_mask;
  lanes_t            cls_a;
  lanes_t            cls_b;
  fedp_class_t       cls_c;
  logic              out_valid;
  logic              out_ready;
  fedp_excep_t       out_excep;
  logic              out_nv;
  logic              out_seq_err;
  logic [CNTW-1:0]   out_steps;

  vx_tcu_drl_excep_acc #(
    .N         (N),
    .PIPE_S1   (1),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_last     (in_last),
    .in_fmt      (in_fmt),
    .in_mask     (in_mask),
    .cls_a       (cls_a),
    .cls_b       (cls_b),
    .cls_c       (cls_c),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_excep   (out_excep),
    .out_nv      (out_nv),
    .out_seq_err (out_seq_err),
    .out_steps   (out_steps)
  );

  always #5 clk = ~clk;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Model state for the open tile.
  bit m_open, m_nan, m_pos, m_neg, m_nv, m_err;
  int m_cnt;

  lanes_t      a_v, b_v;
  fedp_class_t c_v;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic fedp_class_t cl(input bit s, input bit n, input bit i, input bit z);
    fedp_class_t r;
    r.sign = s; r.nan = n; r.inf = i; r.zero = z;
    return r;
  endfunction

  task automatic model_beat(input logic first, input logic last, input logic [2:0] fmt,
                            input logic [TCK-1:0] mask, input lanes_t a, input lanes_t b,
                            input fedp_class_t c);
    bit fok, bn, bp, bg, bv;
    exp_t e;
    fok = (fmt == TCU_FP32_ID) || (fmt == TCU_FP16_ID) || (fmt == TCU_BF16_ID);
    bn = !fok; bv = !fok; bp = 0; bg = 0;
    for (int i = 0; i < int'(TCK); i++) begin
      bit en, iz;
      en = mask[i] && fok && (fmt != TCU_FP32_ID || (i % 2) == 0);
      iz = (a[i].inf && b[i].zero) || (a[i].zero && b[i].inf);
      if (en) begin
        if (a[i].nan || b[i].nan || iz) bn = 1;
        if (iz) bv = 1;
        else if (a[i].inf || b[i].inf) begin
          if (a[i].sign != b[i].sign) bg = 1; else bp = 1;
        end
      end
    end
    if (first) begin
      m_err = m_open;
      m_nan = c.nan; m_pos = c.inf && !c.sign; m_neg = c.inf && c.sign;
      m_nv = 0; m_cnt = 0;
    end else if (!m_open) begin
      m_err = 1; m_nan = 0; m_pos = 0; m_neg = 0; m_nv = 0; m_cnt = 0;
    end
    m_nan = m_nan | bn; m_pos = m_pos | bp; m_neg = m_neg | bg; m_nv = m_nv | bv;
    m_cnt = (m_cnt < int'(MAX_STEPS)) ? m_cnt + 1 : int'(MAX_STEPS);
    if (last) begin
      e.is_nan = m_nan || (m_pos && m_neg);
      e.is_inf = (m_pos || m_neg) && !e.is_nan;
      e.sign   = m_neg && !m_pos;
      e.nv     = m_nv || (m_pos && m_neg);
      e.err    = m_err;
      e.steps  = CNTW'(m_cnt);
      sb.push_back(e);
      m_open = 0;
    end else begin
      m_open = 1;
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, update the model.
  task automatic send(input logic first, input logic last, input logic [2:0] fmt);
    bit acc;
    int guard;
    in_valid = 1'b1; in_first = first; in_last = last; in_fmt = fmt;
    in_mask = '1; cls_a = a_v; cls_b = b_v; cls_c = c_v;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check_val("accept_timeout", 32'(acc), 32'(1));
    else      model_beat(first, last, fmt, in_mask, a_v, b_v, c_v);
    in_valid = 1'b0;
  endtask

  task automatic clear_lanes();
    a_v = '0; b_v = '0; c_v = '0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    check_val("drain", 32'(sb.size()), 32'(0));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check_val("tile.excep", 32'(out_excep), 32'({mon_e.sign, mon_e.is_nan, mon_e.is_inf}));
        check_val("tile.nv", 32'(out_nv), 32'(mon_e.nv));
        check_val("tile.seq_err", 32'(out_seq_err), 32'(mon_e.err));
        check_val("tile.steps", 32'(out_steps), 32'(mon_e.steps));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_fmt = TCU_FP16_ID; in_mask = '0; cls_a = '0; cls_b = '0; cls_c = '0;
    m_open = 0; m_nan = 0; m_pos = 0; m_neg = 0; m_nv = 0; m_err = 0; m_cnt = 0;
    clear_lanes();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.out_valid", 32'(out_valid), 32'(0));
    check_val("rst.in_ready", 32'(in_ready), 32'(1));
    check_val("rst.excep", 32'(out_excep), 32'(0));
    check_val("rst.steps", 32'(out_steps), 32'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single step FP16, lane0 = +inf * +1: latency 2, result +inf.
    clear_lanes();
    a_v[0] = cl(0, 0, 1, 0);
    send(1, 1, TCU_FP16_ID);
    @(negedge clk);
    check_val("lat.s1", 32'(out_valid), 32'(0));
    @(negedge clk);
    check_val("lat.out", 32'(out_valid), 32'(1));
    check_val("single.excep", 32'(out_excep), 32'(3'b001));
    check_val("single.steps", 32'(out_steps), 32'(1));
    wait_drain();

    // Opposite infinities across a 3-step tile.
    clear_lanes(); a_v[1] = cl(0, 0, 1, 0);
    send(1, 0, TCU_FP16_ID);
    clear_lanes();
    send(0, 0, TCU_BF16_ID);
    a_v[3] = cl(1, 0, 1, 0);
    send(0, 1, TCU_FP16_ID);
    wait_drain();

    // TF32: inf*0 on odd lane ignored, on even lane invalid.
    clear_lanes(); a_v[1] = cl(0, 0, 1, 0); b_v[1] = cl(0, 0, 0, 1);
    send(1, 1, TCU_FP32_ID);
    clear_lanes(); a_v[2] = cl(0, 0, 1, 0); b_v[2] = cl(0, 0, 0, 1);
    send(1, 1, TCU_FP32_ID);
    wait_drain();

    // Seeding from c = -inf, then a tile with an unsupported format mid-way.
    clear_lanes(); c_v = cl(1, 0, 1, 0);
    send(1, 0, TCU_FP16_ID);
    c_v = '0;
    send(0, 0, TCU_FP16_ID);
    send(0, 1, TCU_BF16_ID);
    send(1, 0, TCU_FP16_ID);
    send(0, 0, 3'd5);
    send(0, 1, TCU_FP16_ID);
    // Quiet NaN operand: NaN result without invalid flag.
    a_v[0] = cl(0, 1, 0, 0);
    send(1, 1, TCU_BF16_ID);
    wait_drain();

    // Step counter saturation over a 20-step tile.
    clear_lanes();
    send(1, 0, TCU_FP16_ID);
    for (int s = 0; s < 18; s++) send(0, 0, TCU_FP16_ID);
    send(0, 1, TCU_FP16_ID);
    wait_drain();

    // Backpressure with two queued tiles.
    out_ready = 1'b0;
    clear_lanes(); a_v[0] = cl(0, 0, 1, 0);
    send(1, 1, TCU_FP16_ID);
    clear_lanes(); a_v[0] = cl(1, 0, 1, 0);
    send(1, 1, TCU_FP16_ID);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp.in_ready", 32'(in_ready), 32'(0));
      check_val("bp.out_valid", 32'(out_valid), 32'(1));
      check_val("bp.hold_excep", 32'(out_excep), 32'(3'b001));
      check_val("bp.hold_steps", 32'(out_steps), 32'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Sequencing: orphan last beat in IDLE, then first while a tile is open.
    clear_lanes();
    send(0, 1, TCU_FP16_ID);
    a_v[2] = cl(0, 0, 1, 0);
    send(1, 0, TCU_FP16_ID);
    clear_lanes();
    send(1, 1, TCU_FP16_ID);
    wait_drain();

    // Asynchronous reset mid-tile drops it; next tile is clean.
    clear_lanes(); a_v[0] = cl(0, 0, 1, 0);
    send(1, 0, TCU_FP16_ID);
    send(0, 0, TCU_FP16_ID);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst.out_valid", 32'(out_valid), 32'(0));
    check_val("mid_rst.in_ready", 32'(in_ready), 32'(1));
    m_open = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_lanes();
    send(1, 1, TCU_FP16_ID);
    @(negedge clk);
    @(negedge clk);
    check_val("post_rst.out_valid", 32'(out_valid), 32'(1));
    check_val("post_rst.seq_err", 32'(out_seq_err), 32'(0));
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
